hazard_stall_controller: RTL and testbench

- Sequences the 5-stage ARM pipeline (IF, ID, EX, MEM, WB).
- Drives the PC enable, the IF/ID enable and flush, and the control-unit bubble mux select.
- Drives the forwarding selects for the two ID-stage source operands.
- Tracks in-flight destination registers in a 3-entry scoreboard. Detects RAW/load-use hazards and taken-branch flushes, and resolves them by stall, bubble, forward or squash.

---
 rtl/hazard_stall_controller_pkg.sv | 37 +++
 rtl/hazard_scoreboard.sv | 106 ++++++++++
 rtl/hazard_stall_controller.sv | 106 ++++++++++
 tb/tb_hazard_stall_controller.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/hazard_stall_controller_pkg.sv
// Shared types for the pipeline hazard/stall controller: forwarding-select
// encodings, FSM state encoding, scoreboard entry layout and the match helper.
package hazard_stall_controller_pkg;

  // Width of a register index held in a scoreboard entry (R0-R15).
  localparam int SB_RD_W = 4;

  // R15 reads return the PC from the datapath and are never forwarded.
  localparam logic [SB_RD_W-1:0] PC_REG = 4'd15;

  typedef enum logic [1:0] {
    FWD_RF  = 2'b00,
    FWD_EX  = 2'b01,
    FWD_MEM = 2'b10,
    FWD_WB  = 2'b11
  } fwd_sel_e;

  typedef enum logic [1:0] {
    S_RUN   = 2'd0,
    S_STALL = 2'd1,
    S_FLUSH = 2'd2
  } fsm_state_e;

  typedef struct packed {
    logic               valid;
    logic [SB_RD_W-1:0] rd;
    logic               reg_write;
    logic               is_load;
  } sb_entry_t;

  // An in-flight producer matches a source operand only when it really
  // writes that register and the ID instruction really reads it.
  function automatic logic sb_match(sb_entry_t entry, logic [SB_RD_W-1:0] src, logic uses);
    return entry.valid && entry.reg_write && (entry.rd == src) && uses;
  endfunction

endpackage

// File: rtl/hazard_scoreboard.sv
// Three-entry in-flight destination scoreboard (EX, MEM, WB) with RAW
// hazard detection and youngest-first forwarding selection.
module hazard_scoreboard
  import hazard_stall_controller_pkg::*;
#(
  parameter int REG_ADDR_W = 4,
  parameter bit FWD_EN     = 1'b1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  bubble,
  input  logic                  id_valid,
  input  logic [REG_ADDR_W-1:0] id_rn,
  input  logic [REG_ADDR_W-1:0] id_rm,
  input  logic                  id_uses_rn,
  input  logic                  id_uses_rm,
  input  logic [REG_ADDR_W-1:0] id_rd,
  input  logic                  id_reg_write,
  input  logic                  id_is_load,
  output logic                  hazard,
  output logic [1:0]            fwd_a_sel,
  output logic [1:0]            fwd_b_sel
);

  if (REG_ADDR_W != SB_RD_W) begin : g_width_check
    $error("hazard_scoreboard: REG_ADDR_W must equal SB_RD_W");
  end

  sb_entry_t ex_entry;
  sb_entry_t mem_entry;
  sb_entry_t wb_entry;
  sb_entry_t ex_next;

  logic hit_ex_a;
  logic hit_ex_b;
  logic hit_mem_a;
  logic hit_mem_b;
  logic hazard_raw;

  // Load-flag bits of older stages are carried for completeness only.
  logic unused_sb;
  assign unused_sb = ^{ex_entry.is_load, mem_entry.is_load, wb_entry};

  // Youngest producer wins; R15 always comes from the datapath.
  function automatic logic [1:0] pick_fwd(sb_entry_t ex, sb_entry_t mem, sb_entry_t wb,
                                          logic [SB_RD_W-1:0] src, logic uses);
    if (src == PC_REG) begin
      return FWD_RF;
    end else if (sb_match(ex, src, uses)) begin
      return FWD_EX;
    end else if (sb_match(mem, src, uses)) begin
      return FWD_MEM;
    end else if (sb_match(wb, src, uses)) begin
      return FWD_WB;
    end else begin
      return FWD_RF;
    end
  endfunction

  // Build the entry entering EX: a bubble or an empty ID slot leaves it invalid.
  always_comb begin
    ex_next = '0;
    if (id_valid && !bubble) begin
      ex_next.valid     = 1'b1;
      ex_next.rd        = id_rd;
      ex_next.reg_write = id_reg_write;
      ex_next.is_load   = id_is_load;
    end else begin
      ex_next = '0;
    end
  end

  // Advance the pipeline shadow EX -> MEM -> WB every cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ex_entry  <= '0;
      mem_entry <= '0;
      wb_entry  <= '0;
    end else begin
      wb_entry  <= mem_entry;
      mem_entry <= ex_entry;
      ex_entry  <= ex_next;
    end
  end

  // Hazard detection and forwarding selection for both ID source operands.
  always_comb begin
    hit_ex_a  = sb_match(ex_entry,  id_rn, id_uses_rn);
    hit_ex_b  = sb_match(ex_entry,  id_rm, id_uses_rm);
    hit_mem_a = sb_match(mem_entry, id_rn, id_uses_rn);
    hit_mem_b = sb_match(mem_entry, id_rm, id_uses_rm);
    hazard_raw = 1'b0;
    fwd_a_sel  = FWD_RF;
    fwd_b_sel  = FWD_RF;
    if (FWD_EN) begin
      hazard_raw = ex_entry.is_load && (hit_ex_a || hit_ex_b);
      fwd_a_sel  = pick_fwd(ex_entry, mem_entry, wb_entry, id_rn, id_uses_rn);
      fwd_b_sel  = pick_fwd(ex_entry, mem_entry, wb_entry, id_rm, id_uses_rm);
    end else begin
      // Without forwarding, wait until the producer reaches WB.
      hazard_raw = hit_ex_a || hit_ex_b || hit_mem_a || hit_mem_b;
    end
    hazard = id_valid && hazard_raw;
  end

endmodule

// File: rtl/hazard_stall_controller.sv
// Pipeline sequencer for the 5-stage core: stalls on load-use (or any RAW
// when forwarding is off), squashes the slot behind a taken branch, and
// passes the scoreboard's forwarding selects through.
module hazard_stall_controller
  import hazard_stall_controller_pkg::*;
#(
  parameter int REG_ADDR_W = 4,
  parameter bit FWD_EN     = 1'b1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  id_valid,
  input  logic [REG_ADDR_W-1:0] id_rn,
  input  logic [REG_ADDR_W-1:0] id_rm,
  input  logic                  id_uses_rn,
  input  logic                  id_uses_rm,
  input  logic [REG_ADDR_W-1:0] id_rd,
  input  logic                  id_reg_write,
  input  logic                  id_is_load,
  input  logic                  branch_taken,
  output logic                  pc_enable,
  output logic                  if_id_enable,
  output logic                  if_id_flush,
  output logic                  cu_mux_select,
  output logic [1:0]            fwd_a_sel,
  output logic [1:0]            fwd_b_sel
);

  fsm_state_e state;
  fsm_state_e state_next;
  logic       hazard;
  logic [1:0] sb_fwd_a;
  logic [1:0] sb_fwd_b;

  hazard_scoreboard #(
    .REG_ADDR_W (REG_ADDR_W),
    .FWD_EN     (FWD_EN)
  ) u_scoreboard (
    .clk          (clk),
    .reset        (reset),
    .bubble       (cu_mux_select),
    .id_valid     (id_valid),
    .id_rn        (id_rn),
    .id_rm        (id_rm),
    .id_uses_rn   (id_uses_rn),
    .id_uses_rm   (id_uses_rm),
    .id_rd        (id_rd),
    .id_reg_write (id_reg_write),
    .id_is_load   (id_is_load),
    .hazard       (hazard),
    .fwd_a_sel    (sb_fwd_a),
    .fwd_b_sel    (sb_fwd_b)
  );

  // FSM state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= S_RUN;
    end else begin
      state <= state_next;
    end
  end

  // Next-state and pipeline control; reset forces the pass-through values.
  always_comb begin
    state_next    = S_RUN;
    pc_enable     = 1'b1;
    if_id_enable  = 1'b1;
    if_id_flush   = 1'b0;
    cu_mux_select = 1'b0;
    fwd_a_sel     = FWD_RF;
    fwd_b_sel     = FWD_RF;
    if (reset) begin
      state_next = S_RUN;
    end else begin
      fwd_a_sel = sb_fwd_a;
      fwd_b_sel = sb_fwd_b;
      case (state)
        // STALL re-evaluates exactly like RUN, so a cleared hazard resumes
        // in the same cycle and a held branch is acted on immediately.
        S_RUN, S_STALL: begin
          if (hazard) begin
            pc_enable     = 1'b0;
            if_id_enable  = 1'b0;
            cu_mux_select = 1'b1;
            state_next    = S_STALL;
          end else if (branch_taken && id_valid) begin
            if_id_flush = 1'b1;
            pc_enable   = 1'b1;
            state_next  = S_FLUSH;
          end else begin
            state_next = S_RUN;
          end
        end
        // The squashed slot carries no instruction; just let it drain.
        S_FLUSH: begin
          state_next = S_RUN;
        end
        default: begin
          state_next = S_RUN;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_hazard_stall_controller.sv
// Directed bench for hazard_stall_controller: one instance with forwarding,
// one without, driven from the same hand-sequenced instruction stream.
module tb_hazard_stall_controller;
  import hazard_stall_controller_pkg::*;

  logic       clk = 1'b0;
  logic       reset;
  logic       id_valid;
  logic [3:0] id_rn;
  logic [3:0] id_rm;
  logic       id_uses_rn;
  logic       id_uses_rm;
  logic [3:0] id_rd;
  logic       id_reg_write;
  logic       id_is_load;
  logic       branch_taken;

  logic       pc_enable, if_id_enable, if_id_flush, cu_mux_select;
  logic [1:0] fwd_a_sel, fwd_b_sel;
  logic       nf_pc_enable, nf_if_id_enable, nf_if_id_flush, nf_cu_mux_select;
  logic [1:0] nf_fwd_a_sel, nf_fwd_b_sel;

  int n_checks = 0;
  int n_fail   = 0;

  hazard_stall_controller #(.REG_ADDR_W(4), .FWD_EN(1'b1)) dut (
    .clk(clk), .reset(reset), .id_valid(id_valid), .id_rn(id_rn), .id_rm(id_rm),
    .id_uses_rn(id_uses_rn), .id_uses_rm(id_uses_rm), .id_rd(id_rd),
    .id_reg_write(id_reg_write), .id_is_load(id_is_load), .branch_taken(branch_taken),
    .pc_enable(pc_enable), .if_id_enable(if_id_enable), .if_id_flush(if_id_flush),
    .cu_mux_select(cu_mux_select), .fwd_a_sel(fwd_a_sel), .fwd_b_sel(fwd_b_sel)
  );

  hazard_stall_controller #(.REG_ADDR_W(4), .FWD_EN(1'b0)) dut_nf (
    .clk(clk), .reset(reset), .id_valid(id_valid), .id_rn(id_rn), .id_rm(id_rm),
    .id_uses_rn(id_uses_rn), .id_uses_rm(id_uses_rm), .id_rd(id_rd),
    .id_reg_write(id_reg_write), .id_is_load(id_is_load), .branch_taken(branch_taken),
    .pc_enable(nf_pc_enable), .if_id_enable(nf_if_id_enable), .if_id_flush(nf_if_id_flush),
    .cu_mux_select(nf_cu_mux_select), .fwd_a_sel(nf_fwd_a_sel), .fwd_b_sel(nf_fwd_b_sel)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Expected outputs packed as {pc_en, if_id_en, flush, cu_mux, fwd_a, fwd_b}.
  function automatic logic [31:0] pk(input logic pc, input logic en, input logic fl,
                                     input logic cu, input logic [1:0] fa, input logic [1:0] fb);
    return {24'd0, pc, en, fl, cu, fa, fb};
  endfunction

  task automatic expect_fwd(input string tag, input logic [31:0] exp);
    #1;
    check_eq(tag, {24'd0, pc_enable, if_id_enable, if_id_flush, cu_mux_select,
                   fwd_a_sel, fwd_b_sel}, exp);
  endtask

  task automatic expect_nf(input string tag, input logic [31:0] exp);
    #1;
    check_eq(tag, {24'd0, nf_pc_enable, nf_if_id_enable, nf_if_id_flush, nf_cu_mux_select,
                   nf_fwd_a_sel, nf_fwd_b_sel}, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [3:0] rn, input logic [3:0] rm,
                       input logic urn, input logic urm, input logic [3:0] rd,
                       input logic rw, input logic ld, input logic br);
    id_valid     = v;
    id_rn        = rn;
    id_rm        = rm;
    id_uses_rn   = urn;
    id_uses_rm   = urm;
    id_rd        = rd;
    id_reg_write = rw;
    id_is_load   = ld;
    branch_taken = br;
  endtask

  task automatic nop();
    drive(1'b0, 4'd0, 4'd0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    reset = 1'b1;
    // Branch presented during reset must not flush.
    drive(1'b1, 4'd0, 4'd0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b1);
    #2;
    expect_fwd("reset_fwd", pk(1'b1, 1'b1, 1'b0, 1'b0, 2'b00, 2'b00));
    expect_nf("reset_nofwd", pk(1'b1, 1'b1, 1'b0, 1'b0, 2'b00, 2'b00));
    tick();
    reset = 1'b0;
    nop();
    expect_fwd("after_reset", pk(1'b1, 1'b1, 1'b0, 1'b0, 2'b00, 2'b00));

    // LDRB R2,[R1,R0] ; ADD R5,R2,R3 -> one bubble, then forward from MEM.
    drive(1'b1, 4'd1, 4'd0, 1'b1, 1'b1, 4'd2, 1'b1, 1'b1, 1'b0);
    expect_fwd("ldrb_issue", pk(1'b1, 1'b1, 1'b0, 1'b0, 2'b00, 2'b00));
    tick();
    drive(1'b1, 4'd2, 4'd3, 1'b1, 1'b1, 4'd5, 1'b1, 1'b0, 1'b0);
    expect_fwd("loaduse_stall", pk(1'b0, 1'b0, 1'b0, 1'b1, 2'b01, 2'b00));
    tick();
    expect_fwd("loaduse_resume", pk(1'b1, 1'b1, 1'b0, 1'b0, 2'b10, 2'b00));
    tick();

    // ANDS R0,R1,#0 ; ADD R5,R0,R3 -> EX forward.
    drive(1'b1, 4'd1, 4'd0, 1'b1, 1'b0, 4'd0, 1'b1, 1'b0, 1'b0);
    expect_fwd("ands_issue", pk(1'b1, 1'b1, 1'b0, 1'b0, 2'b00, 2'b00));
    tick();
    drive(1'b1, 4'd0, 4'd3, 1'b1, 1'b1, 4'd5, 1'b1, 1'b0, 1'b0);
    expect_fwd("fwd_ex", pk(1'b1, 1'b1, 1'b0, 1'b0, 2'b01, 2'b00));
    tick();

    // One NOP between -> MEM forward.
    drive(1'b1, 4'd1, 4'd0, 1'b1, 1'b0, 4'd0, 1'b1, 1'b0, 1'b0);
    tick();
    nop();
    tick();
    drive(1'b1, 4'd0, 4'd3, 1'b1, 1'b1, 4'd5, 1'b1, 1'b0, 1'b0);
    expect_fwd("fwd_mem", pk(1'b1, 1'b1, 1'b0, 1'b0, 2'b10, 2'b00));
    tick();

    // Two NOPs between, consumer on rm -> WB forward on operand b.
    drive(1'b1, 4'd1, 4'd0, 1'b1, 1'b0, 4'd0, 1'b1, 1'b0, 1'b0);
    tick();
    nop();
    tick();
    tick();
    drive(1'b1, 4'd3, 4'd0, 1'b1, 1'b1, 4'd5, 1'b1, 1'b0, 1'b0);
    expect_fwd("fwd_wb_b", pk(1'b1, 1'b1, 1'b0, 1'b0, 2'b00, 2'b11));
    tick();

    // R0 in EX and MEM: youngest (EX) wins; R5 only in WB.
    drive(1'b1, 4'd1, 4'd0, 1'b1, 1'b0, 4'd0, 1'b1, 1'b0, 1'b0);
    tick();
    drive(1'b1, 4'd0, 4'd0, 1'b1, 1'b1, 4'd0, 1'b1, 1'b0, 1'b0);
    expect_fwd("fwd_ex_both", pk(1'b1, 1'b1, 1'b0, 1'b0, 2'b01, 2'b01));
    tick();
    drive(1'b1, 4'd0, 4'd5, 1'b1, 1'b1, 4'd6, 1'b1, 1'b0, 1'b0);
    expect_fwd("fwd_priority", pk(1'b1, 1'b1, 1'b0, 1'b0, 2'b01, 2'b11));
    tick();

    // Writer of R15 followed by a reader of R15: never forwarded.
    drive(1'b1, 4'd0, 4'd0, 1'b0, 1'b0, 4'd15, 1'b1, 1'b0, 1'b0);
    tick();
    drive(1'b1, 4'd15, 4'd6, 1'b1, 1'b1, 4'd5, 1'b1, 1'b0, 1'b0);
    expect_fwd("r15_no_fwd", pk(1'b1, 1'b1, 1'b0, 1'b0, 2'b00, 2'b10));
    tick();

    // BNE taken -> one flush cycle, FLUSH then RUN; squashed slot leaves no entry.
    drive(1'b1, 4'd0, 4'd0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b1);
    expect_fwd("branch_flush", pk(1'b1, 1'b1, 1'b1, 1'b0, 2'b00, 2'b00));
    tick();
    check_eq("state_flush", 32'(dut.state), 32'(S_FLUSH));
    drive(1'b0, 4'd0, 4'd0, 1'b0, 1'b0, 4'd4, 1'b1, 1'b1, 1'b0);
    expect_fwd("flush_slot", pk(1'b1, 1'b1, 1'b0, 1'b0, 2'b00, 2'b00));
    tick();
    check_eq("state_run", 32'(dut.state), 32'(S_RUN));
    drive(1'b1, 4'd4, 4'd5, 1'b1, 1'b1, 4'd7, 1'b1, 1'b0, 1'b0);
    expect_fwd("no_squash_entry", pk(1'b1, 1'b1, 1'b0, 1'b0, 2'b00, 2'b11));
    tick();

    // Load-use and taken branch together: stall first, flush next cycle.
    drive(1'b1, 4'd1, 4'd0, 1'b1, 1'b1, 4'd2, 1'b1, 1'b1, 1'b0);
    tick();
    drive(1'b1, 4'd2, 4'd0, 1'b1, 1'b0, 4'd0, 1'b0, 1'b0, 1'b1);
    expect_fwd("br_hazard_stall", pk(1'b0, 1'b0, 1'b0, 1'b1, 2'b01, 2'b00));
    tick();
    expect_fwd("br_after_stall", pk(1'b1, 1'b1, 1'b1, 1'b0, 2'b10, 2'b00));
    tick();
    nop();
    check_eq("state_flush2", 32'(dut.state), 32'(S_FLUSH));
    expect_fwd("br_squash", pk(1'b1, 1'b1, 1'b0, 1'b0, 2'b00, 2'b00));
    tick();

    // Reset in the middle of a load-use stall.
    drive(1'b1, 4'd1, 4'd0, 1'b1, 1'b1, 4'd2, 1'b1, 1'b1, 1'b0);
    tick();
    drive(1'b1, 4'd2, 4'd3, 1'b1, 1'b1, 4'd5, 1'b1, 1'b0, 1'b0);
    expect_fwd("pre_reset_stall", pk(1'b0, 1'b0, 1'b0, 1'b1, 2'b01, 2'b00));
    reset = 1'b1;
    expect_fwd("async_reset", pk(1'b1, 1'b1, 1'b0, 1'b0, 2'b00, 2'b00));
    expect_nf("async_reset_nf", pk(1'b1, 1'b1, 1'b0, 1'b0, 2'b00, 2'b00));
    tick();
    reset = 1'b0;
    expect_fwd("post_reset_clean", pk(1'b1, 1'b1, 1'b0, 1'b0, 2'b00, 2'b00));
    expect_nf("post_reset_nf", pk(1'b1, 1'b1, 1'b0, 1'b0, 2'b00, 2'b00));
    nop();
    tick();
    tick();
    tick();

    // No forwarding: ADD R5,R0,R3 after a write to R0 stalls twice.
    drive(1'b1, 4'd1, 4'd0, 1'b1, 1'b0, 4'd0, 1'b1, 1'b0, 1'b0);
    expect_nf("nf_ands", pk(1'b1, 1'b1, 1'b0, 1'b0, 2'b00, 2'b00));
    tick();
    drive(1'b1, 4'd0, 4'd3, 1'b1, 1'b1, 4'd5, 1'b1, 1'b0, 1'b0);
    expect_nf("nf_stall1", pk(1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 2'b00));
    tick();
    expect_nf("nf_stall2", pk(1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 2'b00));
    check_eq("nf_state_stall", 32'(dut_nf.state), 32'(S_STALL));
    tick();
    expect_nf("nf_release", pk(1'b1, 1'b1, 1'b0, 1'b0, 2'b00, 2'b00));
    tick();
    nop();
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_checks, n_fail);
    $finish;
  end

endmodule
